// File: rtl/rom_arbiter.sv
// Two-master arbiter for the single-port boot ROM: grants fetch (m0) or data (m1), forwards strobes and routes rdy_/data back.
// Optional feature: define ROM_ARB_RR_EN for round-robin tie-break (default build is fixed priority, master 0 wins).
module rom_arbiter #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              m0_req_,
  input  logic              m1_req_,
  output logic              m0_grnt_,
  output logic              m1_grnt_,
  input  logic              m0_as_,
  input  logic              m1_as_,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic [DATA_W-1:0] m0_rd_data,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              m0_rdy_,
  output logic              m1_rdy_,
  output logic              rom_cs_,
  output logic              rom_as_,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rd_data,
  input  logic              rom_rdy_
);

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   resp_sel_q;
  logic   resp_pend_q;
  logic   tie_winner;

`ifdef ROM_ARB_RR_EN
  // Master granted most recently; the other one wins the next tie.
  logic last_grnt_q;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      last_grnt_q <= 1'b1;
    end else if (state_q == OWN0) begin
      last_grnt_q <= 1'b0;
    end else if (state_q == OWN1) begin
      last_grnt_q <= 1'b1;
    end
  end

  assign tie_winner = ~last_grnt_q;
`else
  assign tie_winner = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m0_req_ == ENABLE_ && m1_req_ == ENABLE_) begin
          state_d = tie_winner ? OWN1 : OWN0;
        end else if (m0_req_ == ENABLE_) begin
          state_d = OWN0;
        end else if (m1_req_ == ENABLE_) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (m0_req_ == DISABLE_) begin
          state_d = (m1_req_ == ENABLE_) ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (m1_req_ == DISABLE_) begin
          state_d = (m0_req_ == ENABLE_) ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m0_grnt_ = (state_q == OWN0) ? ENABLE_ : DISABLE_;
  assign m1_grnt_ = (state_q == OWN1) ? ENABLE_ : DISABLE_;

  // Only the owner's strobes reach the ROM; a non-granted master is ignored.
  always_comb begin
    rom_cs_  = DISABLE_;
    rom_as_  = DISABLE_;
    rom_addr = '0;
    case (state_q)
      OWN0: begin
        rom_cs_  = ENABLE_;
        rom_as_  = m0_as_;
        rom_addr = m0_addr;
      end
      OWN1: begin
        rom_cs_  = ENABLE_;
        rom_as_  = m1_as_;
        rom_addr = m1_addr;
      end
      default: ;
    endcase
  end

  // Remember who issued the access so the answer follows it across a handover;
  // resp_pend_q also lets reset drop an in-flight response immediately.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      resp_sel_q  <= 1'b0;
      resp_pend_q <= 1'b0;
    end else begin
      resp_pend_q <= (rom_as_ == ENABLE_);
      if (rom_as_ == ENABLE_) begin
        resp_sel_q <= (state_q == OWN1);
      end
    end
  end

  assign m0_rdy_    = (resp_pend_q && !resp_sel_q) ? rom_rdy_    : DISABLE_;
  assign m1_rdy_    = (resp_pend_q &&  resp_sel_q) ? rom_rdy_    : DISABLE_;
  assign m0_rd_data = (resp_pend_q && !resp_sel_q) ? rom_rd_data : '0;
  assign m1_rd_data = (resp_pend_q &&  resp_sel_q) ? rom_rd_data : '0;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed self-checking bench for rom_arbiter with a one-cycle-latency behavioural ROM.
module tb_rom_arbiter;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset_;
  logic              m0_req_, m1_req_;
  logic              m0_grnt_, m1_grnt_;
  logic              m0_as_, m1_as_;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_rd_data, m1_rd_data;
  logic              m0_rdy_, m1_rdy_;
  logic              rom_cs_, rom_as_;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_rd_data;
  logic              rom_rdy_;

  int tests = 0;
  int fails = 0;

  rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_(reset_),
    .m0_req_(m0_req_), .m1_req_(m1_req_),
    .m0_grnt_(m0_grnt_), .m1_grnt_(m1_grnt_),
    .m0_as_(m0_as_), .m1_as_(m1_as_),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_rd_data(m0_rd_data), .m1_rd_data(m1_rd_data),
    .m0_rdy_(m0_rdy_), .m1_rdy_(m1_rdy_),
    .rom_cs_(rom_cs_), .rom_as_(rom_as_), .rom_addr(rom_addr),
    .rom_rd_data(rom_rd_data), .rom_rdy_(rom_rdy_)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    case (a)
      30'h10:  return 32'hDEAD_BEEF;
      30'h4:   return 32'h0000_4444;
      30'h8:   return 32'h8888_0008;
      default: return 32'hC0DE_0000;
    endcase
  endfunction

  // ROM answers one cycle after sampling cs_/as_; it has no reset of its own.
  always @(posedge clk) begin
    rom_rdy_    <= !(rom_cs_ == 1'b0 && rom_as_ == 1'b0);
    rom_rd_data <= (rom_cs_ == 1'b0 && rom_as_ == 1'b0) ? rom_word(rom_addr) : 32'h0;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    m0_req_ = 1'b1; m1_req_ = 1'b1;
    m0_as_  = 1'b1; m1_as_  = 1'b1;
    m0_addr = '0;   m1_addr = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    @(negedge clk);
    reset_ = 1'b0;
    @(negedge clk);
    reset_ = 1'b1;
  endtask

  task automatic test_reset;
    reset_ = 1'b0;
    idle_inputs();
    m0_req_ = 1'b0; m1_req_ = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (m0_grnt_ !== 1'b1) begin fails++; $display("FAIL reset_m0_grnt got %b exp 1", m0_grnt_); end
    tests++; if (m1_grnt_ !== 1'b1) begin fails++; $display("FAIL reset_m1_grnt got %b exp 1", m1_grnt_); end
    tests++; if (rom_cs_ !== 1'b1) begin fails++; $display("FAIL reset_rom_cs got %b exp 1", rom_cs_); end
    tests++; if (rom_as_ !== 1'b1) begin fails++; $display("FAIL reset_rom_as got %b exp 1", rom_as_); end
    tests++; if (m0_rdy_ !== 1'b1 || m1_rdy_ !== 1'b1) begin fails++; $display("FAIL reset_rdy got %b%b exp 11", m0_rdy_, m1_rdy_); end
    tests++; if (rom_addr !== 30'h0) begin fails++; $display("FAIL reset_rom_addr got %h exp 0", rom_addr); end
    tests++; if (m0_rd_data !== 32'h0 || m1_rd_data !== 32'h0) begin fails++; $display("FAIL reset_rd_data got %h %h exp 0 0", m0_rd_data, m1_rd_data); end
    idle_inputs();
    reset_ = 1'b1;
  endtask

  task automatic test_single;
    tick();
    m0_req_ = 1'b0;
    @(negedge clk);
    tests++; if (m0_grnt_ !== 1'b1) begin fails++; $display("FAIL single_grant_c0 got %b exp 1", m0_grnt_); end
    tick();
    m0_as_ = 1'b0; m0_addr = 30'h10;
    @(negedge clk);
    tests++; if (m0_grnt_ !== 1'b0) begin fails++; $display("FAIL single_grant_c1 got %b exp 0", m0_grnt_); end
    tests++; if (rom_addr !== 30'h10) begin fails++; $display("FAIL single_rom_addr got %h exp 10", rom_addr); end
    tests++; if (rom_as_ !== 1'b0 || rom_cs_ !== 1'b0) begin fails++; $display("FAIL single_rom_strobes got cs%b as%b exp 00", rom_cs_, rom_as_); end
    tests++; if (m1_rdy_ !== 1'b1) begin fails++; $display("FAIL single_m1_rdy_c1 got %b exp 1", m1_rdy_); end
    tick();
    m0_as_ = 1'b1;
    @(negedge clk);
    tests++; if (m0_rdy_ !== 1'b0) begin fails++; $display("FAIL single_m0_rdy got %b exp 0", m0_rdy_); end
    tests++; if (m0_rd_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL single_m0_data got %h exp deadbeef", m0_rd_data); end
    tests++; if (m1_rdy_ !== 1'b1 || m1_rd_data !== 32'h0) begin fails++; $display("FAIL single_m1_quiet got %b %h exp 1 0", m1_rdy_, m1_rd_data); end
    tick();
    m0_req_ = 1'b1;
    @(negedge clk);
    tests++; if (m0_rdy_ !== 1'b1) begin fails++; $display("FAIL single_rdy_one_cycle got %b exp 1", m0_rdy_); end
    tick();
    @(negedge clk);
    tests++; if (m0_grnt_ !== 1'b1 || rom_cs_ !== 1'b1) begin fails++; $display("FAIL single_release got grnt%b cs%b exp 11", m0_grnt_, rom_cs_); end
  endtask

  task automatic test_back_to_back;
    tick();
    m1_req_ = 1'b0;
    tick();
    m1_as_ = 1'b0; m1_addr = 30'h10;
    tick();
    m1_addr = 30'h4;
    @(negedge clk);
    tests++; if (m1_rdy_ !== 1'b0 || m1_rd_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL b2b_word0 got %b %h exp 0 deadbeef", m1_rdy_, m1_rd_data); end
    tick();
    m1_as_ = 1'b1;
    @(negedge clk);
    tests++; if (m1_rdy_ !== 1'b0 || m1_rd_data !== 32'h0000_4444) begin fails++; $display("FAIL b2b_word1 got %b %h exp 0 00004444", m1_rdy_, m1_rd_data); end
    tests++; if (m0_rdy_ !== 1'b1) begin fails++; $display("FAIL b2b_m0_quiet got %b exp 1", m0_rdy_); end
    tick();
    m1_req_ = 1'b1;
    tick();
  endtask

  task automatic test_simultaneous;
    logic exp_m1_second;
`ifdef ROM_ARB_RR_EN
    exp_m1_second = 1'b1;
`else
    exp_m1_second = 1'b0;
`endif
    do_reset();
    tick();
    m0_req_ = 1'b0; m1_req_ = 1'b0;
    tick();
    @(negedge clk);
    tests++; if (m0_grnt_ !== 1'b0 || m1_grnt_ !== 1'b1) begin fails++; $display("FAIL tie_first got m0%b m1%b exp 01", m0_grnt_, m1_grnt_); end
    m0_req_ = 1'b1; m1_req_ = 1'b1;
    tick();
    @(negedge clk);
    tests++; if (m0_grnt_ !== 1'b1 || m1_grnt_ !== 1'b1) begin fails++; $display("FAIL tie_idle got m0%b m1%b exp 11", m0_grnt_, m1_grnt_); end
    m0_req_ = 1'b0; m1_req_ = 1'b0;
    tick();
    @(negedge clk);
    tests++; if (m0_grnt_ !== exp_m1_second || m1_grnt_ !== !exp_m1_second) begin fails++; $display("FAIL tie_second got m0%b m1%b exp %b%b", m0_grnt_, m1_grnt_, exp_m1_second, !exp_m1_second); end
    m0_req_ = 1'b1; m1_req_ = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_handover;
    tick();
    m0_req_ = 1'b0;
    tick();
    m1_req_ = 1'b0;
    m0_as_ = 1'b0; m0_addr = 30'h4;
    m0_req_ = 1'b1;
    @(negedge clk);
    tests++; if (rom_as_ !== 1'b0 || rom_addr !== 30'h4) begin fails++; $display("FAIL hand_issue got as%b %h exp 0 4", rom_as_, rom_addr); end
    tick();
    m0_as_ = 1'b1;
    @(negedge clk);
    tests++; if (m1_grnt_ !== 1'b0 || m0_grnt_ !== 1'b1) begin fails++; $display("FAIL hand_grant got m0%b m1%b exp 10", m0_grnt_, m1_grnt_); end
    tests++; if (m0_rdy_ !== 1'b0 || m0_rd_data !== 32'h0000_4444) begin fails++; $display("FAIL hand_m0_resp got %b %h exp 0 00004444", m0_rdy_, m0_rd_data); end
    tests++; if (m1_rdy_ !== 1'b1 || m1_rd_data !== 32'h0) begin fails++; $display("FAIL hand_m1_quiet got %b %h exp 1 0", m1_rdy_, m1_rd_data); end
    tick();
    m1_as_ = 1'b0; m1_addr = 30'h8;
    tick();
    m1_as_ = 1'b1;
    @(negedge clk);
    tests++; if (m1_rdy_ !== 1'b0 || m1_rd_data !== 32'h8888_0008 || m0_rdy_ !== 1'b1) begin fails++; $display("FAIL hand_m1_access got m1 %b %h m0 %b exp 0 88880008 1", m1_rdy_, m1_rd_data, m0_rdy_); end
    tick();
    m1_req_ = 1'b1;
    tick();
  endtask

  task automatic test_non_owner;
    tick();
    m0_req_ = 1'b0; m0_addr = 30'h0;
    tick();
    m1_as_ = 1'b0; m1_addr = 30'h8;
    @(negedge clk);
    tests++; if (rom_as_ !== 1'b1 || rom_addr !== 30'h0) begin fails++; $display("FAIL nonowner_strobe got as%b %h exp 1 0", rom_as_, rom_addr); end
    tick();
    @(negedge clk);
    tests++; if (m0_rdy_ !== 1'b1 || m1_rdy_ !== 1'b1) begin fails++; $display("FAIL nonowner_rdy got %b%b exp 11", m0_rdy_, m1_rdy_); end
    m1_as_ = 1'b1;
    m0_req_ = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_mid_reset;
    tick();
    m0_req_ = 1'b0;
    tick();
    m0_as_ = 1'b0; m0_addr = 30'h10;
    tick();
    m0_as_ = 1'b1;
    reset_ = 1'b0;
    #1;
    tests++; if (m0_rdy_ !== 1'b1 || m0_rd_data !== 32'h0) begin fails++; $display("FAIL midrst_resp got %b %h exp 1 0", m0_rdy_, m0_rd_data); end
    tests++; if (m0_grnt_ !== 1'b1 || m1_grnt_ !== 1'b1) begin fails++; $display("FAIL midrst_grant got m0%b m1%b exp 11", m0_grnt_, m1_grnt_); end
    tests++; if (rom_cs_ !== 1'b1) begin fails++; $display("FAIL midrst_rom_cs got %b exp 1", rom_cs_); end
    m0_req_ = 1'b1;
    @(negedge clk);
    reset_ = 1'b1;
    tick();
    m0_req_ = 1'b0;
    @(negedge clk);
    tests++; if (m0_grnt_ !== 1'b1) begin fails++; $display("FAIL midrst_idle got %b exp 1", m0_grnt_); end
    tick();
    @(negedge clk);
    tests++; if (m0_grnt_ !== 1'b0) begin fails++; $display("FAIL midrst_restart got %b exp 0", m0_grnt_); end
    m0_req_ = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_simultaneous();
    test_handover();
    test_non_owner();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
